// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// pong_pkg : shared state encoding and field limits for the pong match logic
// Rev 1.0
// ============================================================================
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    localparam logic [3:0] FIELD_MAX = 4'd15;
    localparam logic [3:0] FIELD_MIN = 4'd0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_down_counter.sv
`default_nettype none
// ============================================================================
// tick_down_counter : loadable down counter stepped by an enable, stops at zero
// Rev 1.0
// ============================================================================
module tick_down_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// game_ctrl : pong match sequencer (serve / play / point / game-over, scoring)
// Optional macro ATTRACT_EN: ball bounces off both edges while IDLE / OVER.
// Rev 1.0
// ============================================================================
module game_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_TICKS = 500,
    parameter int POINT_TICKS = 1000,
    parameter int WIN_SCORE   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic [3:0]  ball_x,
    input  logic [3:0]  ball_y,
    input  logic [15:0] paddle_l,
    input  logic [15:0] paddle_r,
    output logic        ball_run,
    output logic        ball_load,
    output logic        serve_dir,
    output logic        bounce_x,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [2:0]  state_o,
    output logic        winner
);

    localparam int MAX_TICKS = max_int(SERVE_TICKS, POINT_TICKS);
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_TICKS - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    game_state_t      state_q, state_n;
    logic             start_q;
    logic             start_rise;
    logic             edge_armed, edge_armed_n;
    logic [3:0]       score_l_n, score_r_n;
    logic             ball_run_n, ball_load_n, bounce_x_n;
    logic             serve_dir_n, winner_n;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             at_left, at_right;

    assign start_rise = start & ~start_q;
    assign at_left    = (ball_x == FIELD_MIN);
    assign at_right   = (ball_x == FIELD_MAX);
    assign state_o    = state_q;

    tick_down_counter #(
        .WIDTH (CNT_W)
    ) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            edge_armed <= 1'b1;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            ball_run   <= 1'b0;
            ball_load  <= 1'b0;
            bounce_x   <= 1'b0;
            serve_dir  <= 1'b0;
            winner     <= 1'b0;
        end else begin
            state_q    <= state_n;
            start_q    <= start;
            edge_armed <= edge_armed_n;
            score_l    <= score_l_n;
            score_r    <= score_r_n;
            ball_run   <= ball_run_n;
            ball_load  <= ball_load_n;
            bounce_x   <= bounce_x_n;
            serve_dir  <= serve_dir_n;
            winner     <= winner_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        edge_armed_n = edge_armed;
        score_l_n    = score_l;
        score_r_n    = score_r;
        ball_run_n   = 1'b0;
        ball_load_n  = 1'b0;
        bounce_x_n   = 1'b0;
        serve_dir_n  = serve_dir;
        winner_n     = winner;
        cnt_load     = 1'b0;
        cnt_val      = SERVE_LOAD;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                // A start edge outranks a coincident tick: the tick is dropped.
                if (start_rise) begin
                    score_l_n   = 4'd0;
                    score_r_n   = 4'd0;
                    serve_dir_n = 1'b0;
                    ball_load_n = 1'b1;
                    cnt_load    = 1'b1;
                    cnt_val     = SERVE_LOAD;
                    state_n     = SERVE;
                end
`ifdef ATTRACT_EN
                else begin
                    ball_run_n = 1'b1;
                    if (tick) begin
                        if (at_left || at_right) begin
                            if (edge_armed) begin
                                bounce_x_n   = 1'b1;
                                edge_armed_n = 1'b0;
                            end
                        end else begin
                            edge_armed_n = 1'b1;
                        end
                    end
                end
`endif
            end

            SERVE: begin
                if (tick) begin
                    if (cnt_zero) begin
                        state_n    = PLAY;
                        ball_run_n = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end

            PLAY: begin
                ball_run_n = 1'b1;
                // edge_armed makes each visit to an edge column bounce once only.
                if (tick) begin
                    if (at_left) begin
                        if (edge_armed) begin
                            if (paddle_l[ball_y]) begin
                                bounce_x_n   = 1'b1;
                                edge_armed_n = 1'b0;
                            end else begin
                                score_r_n   = (score_r < WIN) ? score_r + 4'd1 : score_r;
                                serve_dir_n = 1'b0;
                                ball_run_n  = 1'b0;
                                cnt_load    = 1'b1;
                                cnt_val     = POINT_LOAD;
                                state_n     = POINT;
                            end
                        end
                    end else if (at_right) begin
                        if (edge_armed) begin
                            if (paddle_r[ball_y]) begin
                                bounce_x_n   = 1'b1;
                                edge_armed_n = 1'b0;
                            end else begin
                                score_l_n   = (score_l < WIN) ? score_l + 4'd1 : score_l;
                                serve_dir_n = 1'b1;
                                ball_run_n  = 1'b0;
                                cnt_load    = 1'b1;
                                cnt_val     = POINT_LOAD;
                                state_n     = POINT;
                            end
                        end
                    end else begin
                        edge_armed_n = 1'b1;
                    end
                end
            end

            POINT: begin
                if (tick) begin
                    if (cnt_zero) begin
                        if ((score_l == WIN) || (score_r == WIN)) begin
                            state_n  = OVER;
                            winner_n = (score_r == WIN);
                        end else begin
                            ball_load_n  = 1'b1;
                            edge_armed_n = 1'b1;
                            cnt_load     = 1'b1;
                            cnt_val      = SERVE_LOAD;
                            state_n      = SERVE;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
